// File: rtl/tl_a_arbiter.sv
// tl_a_arbiter: two-client TileLink-UH arbiter sharing one downstream A/D pair.
// A channel: round-robin arbitration, grant locked across multi-beat bursts and
// held while an offered beat is stalled; the client index is prepended to source.
// D channel: stateless steering back to the client selected by source MSB.
// Optional: define TL_A_ARBITER_PERF_EN to add saturating per-client
// first-beat grant counters on perf_grant0 / perf_grant1.
module tl_a_arbiter #(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  // client 0
  output logic        in0_a_ready,
  input  logic        in0_a_valid,
  input  logic [2:0]  in0_a_bits_opcode,
  input  logic [2:0]  in0_a_bits_param,
  input  logic [3:0]  in0_a_bits_size,
  input  logic [3:0]  in0_a_bits_source,
  input  logic [27:0] in0_a_bits_address,
  input  logic [7:0]  in0_a_bits_mask,
  input  logic [63:0] in0_a_bits_data,
  input  logic        in0_a_bits_corrupt,
  input  logic        in0_d_ready,
  output logic        in0_d_valid,
  output logic [2:0]  in0_d_bits_opcode,
  output logic [1:0]  in0_d_bits_param,
  output logic [3:0]  in0_d_bits_size,
  output logic [3:0]  in0_d_bits_source,
  output logic        in0_d_bits_sink,
  output logic        in0_d_bits_denied,
  output logic [63:0] in0_d_bits_data,
  output logic        in0_d_bits_corrupt,
  // client 1
  output logic        in1_a_ready,
  input  logic        in1_a_valid,
  input  logic [2:0]  in1_a_bits_opcode,
  input  logic [2:0]  in1_a_bits_param,
  input  logic [3:0]  in1_a_bits_size,
  input  logic [3:0]  in1_a_bits_source,
  input  logic [27:0] in1_a_bits_address,
  input  logic [7:0]  in1_a_bits_mask,
  input  logic [63:0] in1_a_bits_data,
  input  logic        in1_a_bits_corrupt,
  input  logic        in1_d_ready,
  output logic        in1_d_valid,
  output logic [2:0]  in1_d_bits_opcode,
  output logic [1:0]  in1_d_bits_param,
  output logic [3:0]  in1_d_bits_size,
  output logic [3:0]  in1_d_bits_source,
  output logic        in1_d_bits_sink,
  output logic        in1_d_bits_denied,
  output logic [63:0] in1_d_bits_data,
  output logic        in1_d_bits_corrupt,
  // downstream
  input  logic        out_a_ready,
  output logic        out_a_valid,
  output logic [2:0]  out_a_bits_opcode,
  output logic [2:0]  out_a_bits_param,
  output logic [3:0]  out_a_bits_size,
  output logic [4:0]  out_a_bits_source,
  output logic [27:0] out_a_bits_address,
  output logic [7:0]  out_a_bits_mask,
  output logic [63:0] out_a_bits_data,
  output logic        out_a_bits_corrupt,
  output logic        out_d_ready,
  input  logic        out_d_valid,
  input  logic [2:0]  out_d_bits_opcode,
  input  logic [1:0]  out_d_bits_param,
  input  logic [3:0]  out_d_bits_size,
  input  logic [4:0]  out_d_bits_source,
  input  logic        out_d_bits_sink,
  input  logic        out_d_bits_denied,
  input  logic [63:0] out_d_bits_data,
  input  logic        out_d_bits_corrupt
`ifdef TL_A_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1
`endif
);

  localparam logic [3:0] MAX_SIZE_L = 4'(MAX_SIZE);
  localparam logic [3:0] BEAT_SHIFT = 4'($clog2(BEAT_BYTES));

  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic [2:0] beats_left_q, beats_left_d;
  logic       rr_last_q, rr_last_d;
  logic       hold_q, hold_d;

  logic       grant;
  logic       fire;
  logic [3:0] size_eff;
  logic [3:0] beats;

  // Grant: sticky while a burst or a stalled beat is in flight, otherwise round-robin
  always_comb begin
    grant = 1'b0;
    if (lock_q || hold_q) begin
      grant = owner_q;
    end else if (in0_a_valid && !in1_a_valid) begin
      grant = 1'b0;
    end else if (in1_a_valid && !in0_a_valid) begin
      grant = 1'b1;
    end else if (in0_a_valid && in1_a_valid) begin
      grant = ~rr_last_q;
    end
  end

  // A datapath: mux granted client onto the downstream port, tag source with client index
  always_comb begin
    out_a_valid        = grant ? in1_a_valid        : in0_a_valid;
    out_a_bits_opcode  = grant ? in1_a_bits_opcode  : in0_a_bits_opcode;
    out_a_bits_param   = grant ? in1_a_bits_param   : in0_a_bits_param;
    out_a_bits_size    = grant ? in1_a_bits_size    : in0_a_bits_size;
    out_a_bits_source  = {grant, (grant ? in1_a_bits_source : in0_a_bits_source)};
    out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
    out_a_bits_mask    = grant ? in1_a_bits_mask    : in0_a_bits_mask;
    out_a_bits_data    = grant ? in1_a_bits_data    : in0_a_bits_data;
    out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;
    in0_a_ready        = ~grant & out_a_ready;
    in1_a_ready        = grant & out_a_ready;
  end

  // Burst length of the offered message; data-carrying opcodes have bit 2 clear
  always_comb begin
    size_eff = (out_a_bits_size > MAX_SIZE_L) ? MAX_SIZE_L : out_a_bits_size;
    beats    = 4'd1;
    if (!out_a_bits_opcode[2] && (size_eff > BEAT_SHIFT)) begin
      beats = 4'd1 << (size_eff - BEAT_SHIFT);
    end
  end

  assign fire = out_a_valid & out_a_ready;

  // Next state: hold tracks a stalled beat, first beat opens a burst, later beats count down
  always_comb begin
    lock_d       = lock_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    rr_last_d    = rr_last_q;
    hold_d       = out_a_valid & ~out_a_ready;
    if (out_a_valid) begin
      owner_d = grant;
    end
    if (fire) begin
      if (!lock_q) begin
        rr_last_d = grant;
        if (beats > 4'd1) begin
          lock_d       = 1'b1;
          beats_left_d = 3'(beats - 4'd1);
        end
      end else begin
        beats_left_d = beats_left_q - 3'd1;
        if (beats_left_q == 3'd1) begin
          lock_d = 1'b0;
        end
      end
    end
  end

  // State register; rr_last resets to 1 so client 0 wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q       <= 1'b0;
      owner_q      <= 1'b0;
      beats_left_q <= 3'd0;
      rr_last_q    <= 1'b1;
      hold_q       <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      rr_last_q    <= rr_last_d;
      hold_q       <= hold_d;
    end
  end

  // D steering: source MSB picks the client, payload is broadcast
  always_comb begin
    in0_d_valid        = out_d_valid & ~out_d_bits_source[4];
    in1_d_valid        = out_d_valid & out_d_bits_source[4];
    out_d_ready        = out_d_bits_source[4] ? in1_d_ready : in0_d_ready;
    in0_d_bits_opcode  = out_d_bits_opcode;
    in0_d_bits_param   = out_d_bits_param;
    in0_d_bits_size    = out_d_bits_size;
    in0_d_bits_source  = out_d_bits_source[3:0];
    in0_d_bits_sink    = out_d_bits_sink;
    in0_d_bits_denied  = out_d_bits_denied;
    in0_d_bits_data    = out_d_bits_data;
    in0_d_bits_corrupt = out_d_bits_corrupt;
    in1_d_bits_opcode  = out_d_bits_opcode;
    in1_d_bits_param   = out_d_bits_param;
    in1_d_bits_size    = out_d_bits_size;
    in1_d_bits_source  = out_d_bits_source[3:0];
    in1_d_bits_sink    = out_d_bits_sink;
    in1_d_bits_denied  = out_d_bits_denied;
    in1_d_bits_data    = out_d_bits_data;
    in1_d_bits_corrupt = out_d_bits_corrupt;
  end

`ifdef TL_A_ARBITER_PERF_EN
  logic [31:0] perf_grant0_q;
  logic [31:0] perf_grant1_q;
  logic        first_fire;

  assign first_fire  = fire & ~lock_q;
  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;

  // Saturating per-client count of first-beat grants
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant0_q <= 32'd0;
      perf_grant1_q <= 32'd0;
    end else if (first_fire) begin
      if (!grant && (perf_grant0_q != 32'hFFFF_FFFF)) begin
        perf_grant0_q <= perf_grant0_q + 32'd1;
      end
      if (grant && (perf_grant1_q != 32'hFFFF_FFFF)) begin
        perf_grant1_q <= perf_grant1_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed testbench for tl_a_arbiter: arbitration order, burst lock, stall hold,
// D steering, reset mid-burst and (when TL_A_ARBITER_PERF_EN) grant counters.
module tb_tl_a_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_a_ready, in1_a_ready;
  logic        in0_a_valid, in1_a_valid;
  logic [2:0]  in0_a_bits_opcode, in1_a_bits_opcode;
  logic [2:0]  in0_a_bits_param, in1_a_bits_param;
  logic [3:0]  in0_a_bits_size, in1_a_bits_size;
  logic [3:0]  in0_a_bits_source, in1_a_bits_source;
  logic [27:0] in0_a_bits_address, in1_a_bits_address;
  logic [7:0]  in0_a_bits_mask, in1_a_bits_mask;
  logic [63:0] in0_a_bits_data, in1_a_bits_data;
  logic        in0_a_bits_corrupt, in1_a_bits_corrupt;
  logic        in0_d_ready, in1_d_ready;
  logic        in0_d_valid, in1_d_valid;
  logic [2:0]  in0_d_bits_opcode, in1_d_bits_opcode;
  logic [1:0]  in0_d_bits_param, in1_d_bits_param;
  logic [3:0]  in0_d_bits_size, in1_d_bits_size;
  logic [3:0]  in0_d_bits_source, in1_d_bits_source;
  logic        in0_d_bits_sink, in1_d_bits_sink;
  logic        in0_d_bits_denied, in1_d_bits_denied;
  logic [63:0] in0_d_bits_data, in1_d_bits_data;
  logic        in0_d_bits_corrupt, in1_d_bits_corrupt;
  logic        out_a_ready, out_a_valid;
  logic [2:0]  out_a_bits_opcode, out_a_bits_param;
  logic [3:0]  out_a_bits_size;
  logic [4:0]  out_a_bits_source;
  logic [27:0] out_a_bits_address;
  logic [7:0]  out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic        out_a_bits_corrupt;
  logic        out_d_ready, out_d_valid;
  logic [2:0]  out_d_bits_opcode;
  logic [1:0]  out_d_bits_param;
  logic [3:0]  out_d_bits_size;
  logic [4:0]  out_d_bits_source;
  logic        out_d_bits_sink, out_d_bits_denied;
  logic [63:0] out_d_bits_data;
  logic        out_d_bits_corrupt;
`ifdef TL_A_ARBITER_PERF_EN
  logic [31:0] perf_grant0, perf_grant1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  tl_a_arbiter dut (
    .clock(clock), .reset(reset),
    .in0_a_ready(in0_a_ready), .in0_a_valid(in0_a_valid),
    .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
    .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
    .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
    .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
    .in0_d_ready(in0_d_ready), .in0_d_valid(in0_d_valid),
    .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_param(in0_d_bits_param),
    .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
    .in0_d_bits_sink(in0_d_bits_sink), .in0_d_bits_denied(in0_d_bits_denied),
    .in0_d_bits_data(in0_d_bits_data), .in0_d_bits_corrupt(in0_d_bits_corrupt),
    .in1_a_ready(in1_a_ready), .in1_a_valid(in1_a_valid),
    .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
    .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
    .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
    .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
    .in1_d_ready(in1_d_ready), .in1_d_valid(in1_d_valid),
    .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_param(in1_d_bits_param),
    .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
    .in1_d_bits_sink(in1_d_bits_sink), .in1_d_bits_denied(in1_d_bits_denied),
    .in1_d_bits_data(in1_d_bits_data), .in1_d_bits_corrupt(in1_d_bits_corrupt),
    .out_a_ready(out_a_ready), .out_a_valid(out_a_valid),
    .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
    .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
    .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
    .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid),
    .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
    .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
    .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
`ifdef TL_A_ARBITER_PERF_EN
    ,
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    in0_a_valid = 0; in0_a_bits_opcode = 0; in0_a_bits_param = 0; in0_a_bits_size = 0;
    in0_a_bits_source = 0; in0_a_bits_address = 0; in0_a_bits_mask = 0;
    in0_a_bits_data = 0; in0_a_bits_corrupt = 0; in0_d_ready = 0;
    in1_a_valid = 0; in1_a_bits_opcode = 0; in1_a_bits_param = 0; in1_a_bits_size = 0;
    in1_a_bits_source = 0; in1_a_bits_address = 0; in1_a_bits_mask = 0;
    in1_a_bits_data = 0; in1_a_bits_corrupt = 0; in1_d_ready = 0;
    out_a_ready = 0; out_d_valid = 0; out_d_bits_opcode = 0; out_d_bits_param = 0;
    out_d_bits_size = 0; out_d_bits_source = 0; out_d_bits_sink = 0;
    out_d_bits_denied = 0; out_d_bits_data = 0; out_d_bits_corrupt = 0;
  endtask

  // Drive a valid A request on one client (source 2 for client 0, 7 for client 1)
  task automatic drive_a(input bit client, input logic [2:0] opc, input logic [3:0] size,
                         input logic [63:0] data);
    if (!client) begin
      in0_a_valid = 1; in0_a_bits_opcode = opc; in0_a_bits_size = size;
      in0_a_bits_source = 4'h2; in0_a_bits_address = 28'h000_1000;
      in0_a_bits_mask = 8'hFF; in0_a_bits_data = data;
    end else begin
      in1_a_valid = 1; in1_a_bits_opcode = opc; in1_a_bits_size = size;
      in1_a_bits_source = 4'h7; in1_a_bits_address = 28'h000_2000;
      in1_a_bits_mask = 8'hFF; in1_a_bits_data = data;
    end
  endtask

  // Check which client the downstream A port currently shows
  task automatic check_grant(input string tag, input bit g);
    check_val({tag, ".src"}, 64'(out_a_bits_source), g ? 64'h17 : 64'h02);
    check_val({tag, ".addr"}, 64'(out_a_bits_address), g ? 64'h2000 : 64'h1000);
  endtask

  bit exp_rr [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    idle_all();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check_val("idle.a_valid", 64'(out_a_valid), 64'h0);
    check_val("idle.a_source", 64'(out_a_bits_source), 64'h0);
    check_val("idle.d_ready", 64'(out_d_ready), 64'h0);
    check_val("idle.in0_d_valid", 64'(in0_d_valid), 64'h0);

    // 1: both clients Get with ready high -> alternate 0,1,0,1
    drive_a(0, 3'd4, 4'd3, 64'h0);
    drive_a(1, 3'd4, 4'd3, 64'h0);
    out_a_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("rr cycle %0d: source=%0h", i, out_a_bits_source);
      check_grant($sformatf("rr%0d", i), exp_rr[i]);
      check_val($sformatf("rr%0d.rdy1", i), 64'(in1_a_ready), 64'(exp_rr[i]));
      tick();
    end

    // 2: client 0 PutFullData size 5 (4 beats) while client 1 waits
    for (int b = 0; b < 4; b++) begin
      drive_a(0, 3'd0, 4'd5, 64'hA0 + 64'(b));
      #1;
      $display("burst beat %0d: source=%0h data=%0h", b, out_a_bits_source, out_a_bits_data);
      check_grant($sformatf("burst%0d", b), 1'b0);
      check_val($sformatf("burst%0d.data", b), out_a_bits_data, 64'hA0 + 64'(b));
      check_val($sformatf("burst%0d.rdy1", b), 64'(in1_a_ready), 64'h0);
      tick();
    end
    drive_a(0, 3'd4, 4'd3, 64'h0);
    #1;
    check_grant("after_burst", 1'b1);
    check_val("after_burst.rdy1", 64'(in1_a_ready), 64'h1);
    tick();
    idle_all();

    // 3: client 1 stalled; client 0 arrives mid-stall and must wait
    drive_a(1, 3'd4, 4'd3, 64'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_a(0, 3'd4, 4'd3, 64'h0);
      #1;
      $display("stall cycle %0d: source=%0h", c, out_a_bits_source);
      check_grant($sformatf("stall%0d", c), 1'b1);
      check_val($sformatf("stall%0d.valid", c), 64'(out_a_valid), 64'h1);
      tick();
    end
    out_a_ready = 1;
    #1;
    check_grant("stall_fire", 1'b1);
    tick();
    in1_a_valid = 0;
    #1;
    check_grant("stall_next", 1'b0);
    check_val("stall_next.valid", 64'(out_a_valid), 64'h1);
    tick();
    idle_all();

    // 4: D steering by source MSB
    out_d_valid = 1; out_d_bits_source = 5'b1_0011; out_d_bits_data = 64'hDEAD_BEEF;
    in0_d_ready = 1; in1_d_ready = 0;
    #1;
    $display("d route source=%0h", out_d_bits_source);
    check_val("d1.in1_valid", 64'(in1_d_valid), 64'h1);
    check_val("d1.in1_source", 64'(in1_d_bits_source), 64'h3);
    check_val("d1.in0_valid", 64'(in0_d_valid), 64'h0);
    check_val("d1.d_ready", 64'(out_d_ready), 64'h0);
    check_val("d1.in0_data", in0_d_bits_data, 64'hDEAD_BEEF);
    out_d_bits_source = 5'b0_0101;
    #1;
    check_val("d0.in0_valid", 64'(in0_d_valid), 64'h1);
    check_val("d0.in1_valid", 64'(in1_d_valid), 64'h0);
    check_val("d0.d_ready", 64'(out_d_ready), 64'h1);
    check_val("d0.in0_source", 64'(in0_d_bits_source), 64'h5);
    idle_all();
    tick();

    // 5: reset after beat 2 of an 8-beat Put from client 0
    drive_a(0, 3'd0, 4'd6, 64'h55);
    out_a_ready = 1;
    for (int b = 0; b < 2; b++) begin
      #1;
      check_grant($sformatf("put8_%0d", b), 1'b0);
      tick();
    end
    idle_all();
    reset = 1;
    tick();
    reset = 0;
    drive_a(0, 3'd4, 4'd3, 64'h0);
    drive_a(1, 3'd4, 4'd3, 64'h0);
    #1;
    $display("post-reset tie: source=%0h", out_a_bits_source);
    check_grant("rst_tie", 1'b0);
    in0_a_valid = 0;
    #1;
    check_val("rst_unlock.valid", 64'(out_a_valid), 64'h1);
    check_grant("rst_unlock", 1'b1);
    idle_all();
    tick();

`ifdef TL_A_ARBITER_PERF_EN
    // 6: counters since the last reset: 3 client-0 Gets, 1 client-1 Get
    reset = 1;
    tick();
    reset = 0;
    out_a_ready = 1;
    for (int k = 0; k < 4; k++) begin
      in0_a_valid = 0; in1_a_valid = 0;
      drive_a(k == 3, 3'd4, 4'd3, 64'h0);
      tick();
    end
    idle_all();
    #1;
    check_val("perf0", 64'(perf_grant0), 64'd3);
    check_val("perf1", 64'(perf_grant1), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Two-client TileLink-UH arbiter that shares one downstream A/D port pair between two upstream masters.
- Merges A requests with round-robin arbitration, locks the grant across multi-beat data bursts, and tags the source ID with the client index.
- Steers D responses back by source MSB.
- Sits between client adapters and the single-port pass-through crossbar feeding the peripheral bus.

Parameters:
- BEAT_BYTES, 8: data bus width in bytes; fixed at 8 (64-bit data); beat math depends on it.
- MAX_SIZE, 6: largest log2 transfer size accepted; max burst = 2^MAX_SIZE/BEAT_BYTES = 8 beats.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- inN_a_ready  out  1  A accept to client N (N = 0, 1; every inN_ line is instantiated for both clients)
- inN_a_valid  in  1  A request valid
- inN_a_bits_opcode  in  3
- inN_a_bits_param  in  3
- inN_a_bits_size  in  4
- inN_a_bits_source  in  4
- inN_a_bits_address  in  28
- inN_a_bits_mask  in  8
- inN_a_bits_data  in  64
- inN_a_bits_corrupt  in  1
- inN_d_ready  in  1
- inN_d_valid  out  1
- inN_d_bits_{opcode 3, param 2, size 4, source 4, sink 1, denied 1, data 64, corrupt 1}  out  D payload to client N
- out_a_ready  in  1
- out_a_valid  out  1
- out_a_bits_{opcode 3, param 3, size 4, source 5, address 28, mask 8, data 64, corrupt 1}  out  merged A
- out_d_ready  out  1
- out_d_valid  in  1
- out_d_bits_{opcode 3, param 2, size 4, source 5, sink 1, denied 1, data 64, corrupt 1}  in

Behaviour:
- State registers:
  - lock: 1 bit, burst in progress.
  - owner: 1 bit, currently granted client.
  - beats_left: 3 bits.
  - rr_last: 1 bit, last client granted a first beat.
  - hold: 1 bit, offered beat not yet accepted.
- Reset values: lock=0, hold=0, beats_left=0, rr_last=1, so client 0 wins the first tie.
- With all inputs idle, outputs are 0. All outputs are combinational from inputs and state; zero added latency.
- Grant selection:
  - If lock or hold: grant = owner.
  - Otherwise, if exactly one inN_a_valid: grant that client.
  - Otherwise, if both valid: grant !rr_last.
- A datapath:
  - out_a_valid = in[grant]_a_valid.
  - Payload is muxed from the granted client.
  - out_a_bits_source = {grant, in[grant]_a_bits_source}.
  - in[grant]_a_ready = out_a_ready; the non-granted inN_a_ready = 0.
- hold:
  - Set when out_a_valid & !out_a_ready; owner := grant.
  - Cleared on fire.
  - Guarantees the grant never switches under a pending beat.
- Beat count:
  - Opcodes 0..3 carry data: beats = max(1, 2^size >> 3).
  - Opcodes 4..7: beats = 1.
  - size > MAX_SIZE is treated as MAX_SIZE.
- First-beat fire (out_a_valid & out_a_ready & !lock):
  - rr_last := grant; owner := grant.
  - If beats > 1: lock := 1, beats_left := beats - 1.
- Fire while lock: beats_left decrements; when it reaches 0 (last beat fires), lock := 0 in the same edge. The next cycle is open arbitration.
- D routing:
  - inN_d_valid = out_d_valid & (out_d_bits_source[4] == N).
  - inN_d_bits_source = out_d_bits_source[3:0]; other D payload is broadcast to both clients.
  - out_d_ready = in[out_d_bits_source[4]]_d_ready.
  - D is stateless and independent of A lock.
- Simultaneous events:
  - A new request arriving on the last beat's cycle is not granted until the following cycle.
  - Both clients valid while locked: the locked owner continues.
- Reset asserted mid-burst: all state clears next edge. A partially-sent burst is abandoned; clients must also reset.

Optional Feature:
- Macro: TL_A_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_grant0 and perf_grant1, each out 32.
  - Each counts first-beat fires for its client.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Both clients valid with Get (opcode 4), out_a_ready=1 for 4 cycles -> grants 0,1,0,1; out_a_bits_source MSB follows the same sequence.
2. Client 0 sends PutFullData size=5 (4 beats), client 1 valid throughout -> 4 consecutive client-0 beats, then client 1 granted on cycle 5; in1_a_ready=0 during cycles 1-4.
3. Client 1 alone valid with out_a_ready=0 for 3 cycles, client 0 raises valid on cycle 2 -> grant stays 1 until fire; client 0 is granted next.
4. out_d_valid with source 5'b1_0011, in1_d_ready=0 -> in1_d_valid=1, in1_d_bits_source=3, in0_d_valid=0, out_d_ready=0.
5. Reset pulsed after beat 2 of an 8-beat Put -> lock=0 and client 0 wins the next tie.
6. With TL_A_ARBITER_PERF_EN, 3 single-beat client-0 grants and 1 client-1 grant -> perf_grant0=3, perf_grant1=1.
